// File: rtl/dds_pkg.sv
// Shared widths and state encoding for the DDS AM sequencer.
package dds_pkg;
  localparam int DDS_ACC_W  = 32;
  localparam int DDS_ADDR_W = 10;
  localparam int DDS_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } dds_state_e;
endpackage

// File: rtl/dds_am_phase_acc.sv
// Phase accumulator with double-buffered tuning word.
// A new tuning word takes effect at the period wrap so periods stay whole.
module dds_am_phase_acc
  import dds_pkg::*;
#(
  parameter int ACC_W  = DDS_ACC_W,
  parameter int ADDR_W = DDS_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              idle,
  input  logic              step,
  input  logic              sync,
  input  logic [ACC_W-1:0]  ftw,
  input  logic              ftw_load,
  output logic [ADDR_W-1:0] phase_addr,
  output logic              carry
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] pend_q, pend_d;
  logic [ACC_W-1:0] act_q, act_d;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;

  always_comb begin
    base       = sync ? '0 : acc_q;
    sum        = {1'b0, base} + {1'b0, act_q};
    phase_addr = base[ACC_W-1 -: ADDR_W];
    carry      = sum[ACC_W];
    acc_d      = acc_q;
    pend_d     = pend_q;
    act_d      = act_q;
    if (step) begin
      acc_d = sum[ACC_W-1:0];
    end else if (sync) begin
      acc_d = '0;
    end
    if (ftw_load) begin
      pend_d = ftw;
    end
    // While idle there is no period to protect, so follow pending at once.
    if (idle) begin
      act_d = pend_d;
    end else if (step && carry) begin
      act_d = pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= '0;
      pend_q <= '0;
      act_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end
endmodule

// File: rtl/dds_am_sequencer.sv
// DDS amplitude-modulation table sequencer.
// Walks an AM table by phase accumulation with a fixed 3-cycle read pipeline.
module dds_am_sequencer
  import dds_pkg::*;
#(
  parameter int ACC_W  = DDS_ACC_W,
  parameter int ADDR_W = DDS_ADDR_W,
  parameter int DATA_W = DDS_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    mode_oneshot,
  input  logic                    trigger,
  input  logic                    sample_en,
  input  logic [ACC_W-1:0]        ftw,
  input  logic                    ftw_load,
  input  logic                    phase_sync,
  output logic [ADDR_W-1:0]       ram_address,
  output logic                    ram_chipselect,
  input  logic [DATA_W-1:0]       ram_readdata,
  output logic                    ram_write,
  output logic [(DATA_W+7)/8-1:0] ram_byteenable,
  output logic                    ram_clken,
  output logic [DATA_W-1:0]       am_sample,
  output logic                    am_valid,
  output logic                    busy,
  output logic                    done
);
  dds_state_e        state_q, state_d;
  logic              drain_done_q, drain_done_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] phase_addr;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              step, carry, idle;

  assign idle = (state_q == ST_IDLE);
  assign step = (state_q == ST_RUN) & enable & sample_en;

  dds_am_phase_acc #(
    .ACC_W (ACC_W),
    .ADDR_W(ADDR_W)
  ) u_phase_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .idle      (idle),
    .step      (step),
    .sync      (phase_sync),
    .ftw       (ftw),
    .ftw_load  (ftw_load),
    .phase_addr(phase_addr),
    .carry     (carry)
  );

  always_comb begin
    state_d      = state_q;
    drain_done_d = drain_done_q;
    done_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && (!mode_oneshot || trigger)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d      = ST_DRAIN;
          drain_done_d = 1'b0;
        end else if (sample_en && carry && mode_oneshot) begin
          state_d      = ST_DRAIN;
          drain_done_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        // rd_q clear means the last read's am_valid is already showing.
        if (!cs_q && !rd_q) begin
          state_d = ST_IDLE;
          done_d  = drain_done_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cs_d     = step;
    addr_d   = step ? phase_addr : addr_q;
    rd_d     = cs_q;
    valid_d  = rd_q;
    sample_d = rd_q ? ram_readdata : sample_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      drain_done_q <= 1'b0;
      cs_q         <= 1'b0;
      rd_q         <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      addr_q       <= '0;
      sample_q     <= '0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
      cs_q         <= cs_d;
      rd_q         <= rd_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      addr_q       <= addr_d;
      sample_q     <= sample_d;
    end
  end

  assign ram_address    = addr_q;
  assign ram_chipselect = cs_q;
  assign ram_write      = 1'b0;
  assign ram_byteenable = '1;
  assign ram_clken      = 1'b1;
  assign am_sample      = sample_q;
  assign am_valid       = valid_q;
  assign busy           = !idle;
  assign done           = done_q;
endmodule

// File: tb/tb_dds_am_sequencer.sv
// Bench for dds_am_sequencer: behavioural model plus directed scenarios.
module tb_dds_am_sequencer;
  logic        clk = 1'b0;
  logic        reset_n, enable, mode_oneshot, trigger;
  logic        sample_en, ftw_load, phase_sync;
  logic [31:0] ftw;
  logic [9:0]  ram_address;
  logic        ram_chipselect;
  logic [15:0] ram_readdata;
  logic        ram_write;
  logic [1:0]  ram_byteenable;
  logic        ram_clken;
  logic [15:0] am_sample;
  logic        am_valid, busy, done;

  logic [15:0] mem [1024];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_readdata <= mem[ram_address];

  dds_am_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .mode_oneshot  (mode_oneshot),
    .trigger       (trigger),
    .sample_en     (sample_en),
    .ftw           (ftw),
    .ftw_load      (ftw_load),
    .phase_sync    (phase_sync),
    .ram_address   (ram_address),
    .ram_chipselect(ram_chipselect),
    .ram_readdata  (ram_readdata),
    .ram_write     (ram_write),
    .ram_byteenable(ram_byteenable),
    .ram_clken     (ram_clken),
    .am_sample     (am_sample),
    .am_valid      (am_valid),
    .busy          (busy),
    .done          (done)
  );

  // Model: 0 idle, 1 running, 2 draining.
  typedef struct {
    int          due;
    logic [15:0] val;
  } rd_t;

  rd_t         q[$];
  int          ms = 0;
  int          mstep = 0;
  bit [31:0]   m_acc, m_pend, m_act;
  bit          m_dflag;
  logic        e_cs, e_valid, e_busy, e_done;
  logic [9:0]  e_addr;
  logic [15:0] e_sample;

  int cap_a[$];
  int cap_v[$];
  int v_cyc[$];
  int done_cyc[$];

  task automatic chk(input string name, input logic [63:0] actual,
                     input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                 name, cyc, actual, required);
    end
  endtask

  task automatic model_step();
    bit        was_empty, issued;
    bit [31:0] base, old_pend;
    bit [32:0] sum;
    int        nms;
    rd_t       r;
    mstep++;
    e_cs = 0;
    e_valid = 0;
    e_done = 0;
    if (reset_n !== 1'b1) begin
      ms = 0; m_acc = 0; m_pend = 0; m_act = 0; m_dflag = 0;
      q.delete();
      e_addr = 0; e_sample = 0; e_busy = 0;
      return;
    end
    was_empty = (q.size() == 0);
    if (q.size() > 0 && q[0].due == mstep) begin
      e_valid = 1;
      e_sample = q[0].val;
      void'(q.pop_front());
    end
    old_pend = m_pend;
    issued = 0;
    nms = ms;
    case (ms)
      0: if (enable && (!mode_oneshot || trigger)) nms = 1;
      1: begin
        if (!enable) begin
          nms = 2;
          m_dflag = 0;
        end else if (sample_en) begin
          base = phase_sync ? 32'd0 : m_acc;
          sum = {1'b0, base} + {1'b0, m_act};
          issued = 1;
          e_cs = 1;
          e_addr = base[31:22];
          r.due = mstep + 2;
          r.val = mem[base[31:22]];
          q.push_back(r);
          m_acc = sum[31:0];
          if (sum[32]) begin
            m_act = old_pend;
            if (mode_oneshot) begin
              nms = 2;
              m_dflag = 1;
            end
          end
        end
      end
      default: begin
        if (was_empty) begin
          nms = 0;
          e_done = m_dflag;
        end
      end
    endcase
    if (phase_sync && !issued) m_acc = 0;
    if (ftw_load) m_pend = ftw;
    if (ms == 0) m_act = m_pend;
    ms = nms;
    e_busy = (ms != 0);
  endtask

  task automatic observe();
    chk("chipselect", ram_chipselect, e_cs);
    chk("address", ram_address, e_addr);
    chk("am_valid", am_valid, e_valid);
    chk("am_sample", am_sample, e_sample);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    if (ram_chipselect === 1'b1) cap_a.push_back(int'(ram_address));
    if (am_valid === 1'b1) begin
      cap_v.push_back(int'(am_sample));
      v_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
    observe();
  endtask

  task automatic clear_caps();
    cap_a.delete();
    cap_v.delete();
    v_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic quiet(input int n);
    enable = 0; trigger = 0; sample_en = 0;
    ftw_load = 0; phase_sync = 0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset_n = 0;
    quiet(1);
    reset_n = 1;
  endtask

  task automatic load_ftw(input logic [31:0] w);
    ftw = w;
    ftw_load = 1;
    tick();
    ftw_load = 0;
  endtask

  initial begin
    int s;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
    reset_n = 0; enable = 0; mode_oneshot = 0; trigger = 0;
    sample_en = 0; ftw = 0; ftw_load = 0; phase_sync = 0;

    // Reset state and integration tie-offs
    do_reset();
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_valid", am_valid, 0);
    chk("rst_sample", am_sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("tie_write", ram_write, 0);
    chk("tie_be", ram_byteenable, 2'b11);
    chk("tie_clken", ram_clken, 1);

    // Continuous sweep, step 1
    load_ftw(32'h0040_0000);
    enable = 1;
    tick();
    clear_caps();
    s = cyc;
    sample_en = 1;
    repeat (1028) tick();
    chk("t1_count_ok", cap_v.size() >= 1025, 1);
    if (cap_v.size() >= 1025) begin
      int bad = 0;
      for (int i = 0; i < 1025; i++) if (cap_v[i] != (i % 1024)) bad++;
      chk("t1_seq_errs", bad, 0);
      chk("t1_latency", v_cyc[0] - s, 3);
      chk("t1_v0", cap_v[0], 0);
      chk("t1_v1", cap_v[1], 1);
      chk("t1_v1023", cap_v[1023], 1023);
      chk("t1_v1024", cap_v[1024], 0);
    end
    quiet(6);

    // One-shot quarter steps
    do_reset();
    load_ftw(32'h4000_0000);
    mode_oneshot = 1; enable = 1; trigger = 1;
    tick();
    trigger = 0;
    clear_caps();
    sample_en = 1;
    repeat (12) tick();
    chk("t2_nreads", cap_a.size(), 4);
    chk("t2_nvalid", v_cyc.size(), 4);
    chk("t2_ndone", done_cyc.size(), 1);
    if (cap_a.size() == 4) begin
      chk("t2_a0", cap_a[0], 0);
      chk("t2_a1", cap_a[1], 256);
      chk("t2_a2", cap_a[2], 512);
      chk("t2_a3", cap_a[3], 768);
    end
    if (v_cyc.size() == 4 && done_cyc.size() == 1)
      chk("t2_done_at", done_cyc[0] - v_cyc[3], 1);
    chk("t2_busy_end", busy, 0);
    quiet(4);
    mode_oneshot = 0;

    // Tuning word change defers to the wrap
    do_reset();
    load_ftw(32'h0040_0000);
    enable = 1;
    tick();
    clear_caps();
    sample_en = 1;
    repeat (500) tick();
    ftw = 32'h0080_0000;
    ftw_load = 1;
    tick();
    ftw_load = 0;
    repeat (560) tick();
    chk("t3_count_ok", cap_a.size() >= 1027, 1);
    if (cap_a.size() >= 1027) begin
      chk("t3_a600", cap_a[600], 600);
      chk("t3_a1023", cap_a[1023], 1023);
      chk("t3_a1024", cap_a[1024], 0);
      chk("t3_a1025", cap_a[1025], 2);
      chk("t3_a1026", cap_a[1026], 4);
    end
    quiet(6);

    // Phase sync coincident with a sample
    do_reset();
    load_ftw(32'h1234_5678);
    enable = 1;
    tick();
    clear_caps();
    sample_en = 1;
    tick();
    sample_en = 0;
    tick();
    sample_en = 1;
    phase_sync = 1;
    tick();
    phase_sync = 0;
    tick();
    sample_en = 0;
    quiet(5);
    chk("t4_nreads", cap_a.size(), 3);
    if (cap_a.size() == 3) begin
      chk("t4_sync_addr", cap_a[1], 0);
      chk("t4_next_addr", cap_a[2], 10'h048);
    end

    // Reset mid-run
    do_reset();
    load_ftw(32'h0040_0000);
    enable = 1;
    tick();
    sample_en = 1;
    repeat (20) tick();
    reset_n = 0;
    enable = 0;
    tick();
    chk("t5_cs", ram_chipselect, 0);
    chk("t5_addr", ram_address, 0);
    chk("t5_valid", am_valid, 0);
    chk("t5_sample", am_sample, 0);
    chk("t5_busy", busy, 0);
    reset_n = 1;
    clear_caps();
    quiet(5);
    chk("t5_stale_valid", v_cyc.size(), 0);
    chk("t5_stale_cs", cap_a.size(), 0);

    // Enable falls mid-run
    do_reset();
    load_ftw(32'h0040_0000);
    enable = 1;
    tick();
    sample_en = 1;
    repeat (20) tick();
    clear_caps();
    enable = 0;
    repeat (8) tick();
    chk("t6_no_cs", cap_a.size(), 0);
    chk("t6_trailing", v_cyc.size(), 2);
    chk("t6_no_done", done_cyc.size(), 0);
    chk("t6_idle", busy, 0);
    quiet(2);

    // Randomized traffic against the model
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      reset_n = ($urandom_range(199) != 0);
      enable = ($urandom_range(15) != 0);
      if ($urandom_range(49) == 0) mode_oneshot = ~mode_oneshot;
      trigger = ($urandom_range(7) == 0);
      sample_en = $urandom_range(1);
      ftw_load = ($urandom_range(19) == 0);
      ftw = ($urandom_range(7) == 0) ? 32'd0 : 32'($urandom);
      phase_sync = ($urandom_range(29) == 0);
      tick();
    end
    reset_n = 1;
    quiet(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
